// File: rtl/fft_pwr_avg.sv
// fft_pwr_avg: per-bin FFT power averaged over 2^AVG_LOG2 good frames, saturated into a readable result RAM
module fft_pwr_avg #(
  parameter int DATA_W    = 16,
  parameter int LOG2_NPTS = 10,
  parameter int NPTS      = 1024,
  parameter int AVG_LOG2  = 2,
  parameter int PWR_SHIFT = 16,
  parameter int OUT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 src_valid,
  output logic                 src_ready,
  input  logic [1:0]           src_error,
  input  logic                 src_sop,
  input  logic                 src_eop,
  input  logic [DATA_W-1:0]    src_real,
  input  logic [DATA_W-1:0]    src_imag,
  input  logic [LOG2_NPTS-1:0] rd_addr,
  output logic [OUT_W-1:0]     rd_data,
  output logic                 frame_done,
  output logic [7:0]           err_count
);
  localparam int PW = 2*DATA_W;
  localparam int AW = PW + AVG_LOG2;
  localparam int SH = AVG_LOG2 + PWR_SHIFT;
  localparam logic [LOG2_NPTS-1:0] LAST = LOG2_NPTS'(NPTS-1);
  localparam logic [AW-1:0] RMAX = {{(AW-OUT_W){1'b0}}, {OUT_W{1'b1}}};
  typedef enum logic {IDLE, IN_FRAME} state_t;
  state_t state, state_n;
  logic [LOG2_NPTS-1:0] bin_cnt, bin_n, addr;
  logic [AVG_LOG2-1:0]  frame_idx, fidx_n, fi;
  logic beat, proc, abort, good, first, last;
  logic v1, v2, v3, f1, f2, f3, l1, l2, l3, d1, d2;
  logic signed [DATA_W-1:0] re1, im1;
  logic [LOG2_NPTS-1:0] a1, a2, a3;
  logic [PW-1:0] sq_re2, sq_im2, pwr3;
  logic [AW-1:0] acc_q, acc3, acc_new, shifted;
  logic [OUT_W-1:0] res;
  logic [AW-1:0]    acc_ram [NPTS];
  logic [OUT_W-1:0] res_ram [NPTS];
  assign beat = src_valid & src_ready;
  // a non-sop beat in IDLE is ignored; everything else is framed or aborted here
  always_comb begin
    state_n = state;
    bin_n = bin_cnt;
    proc = 1'b0;
    abort = 1'b0;
    good = 1'b0;
    addr = bin_cnt;
    if (beat && (state == IN_FRAME || src_sop)) begin
      if (src_error != 2'b00 || (src_sop && src_eop)) begin
        abort = 1'b1;
        state_n = IDLE;
        bin_n = '0;
      end else if (src_sop) begin
        abort = state == IN_FRAME;
        proc = 1'b1;
        addr = '0;
        bin_n = LOG2_NPTS'(1);
        state_n = IN_FRAME;
      end else if (src_eop != (bin_cnt == LAST)) begin
        abort = 1'b1;
        state_n = IDLE;
        bin_n = '0;
      end else begin
        proc = 1'b1;
        good = src_eop;
        bin_n = src_eop ? '0 : bin_cnt + LOG2_NPTS'(1);
        state_n = src_eop ? IDLE : IN_FRAME;
      end
    end
    fidx_n = abort ? '0 : good ? frame_idx + AVG_LOG2'(1) : frame_idx;
  end
  // a restarting sop beat belongs to the new group, so its frame index is 0
  assign fi = abort ? '0 : frame_idx;
  assign first = fi == '0;
  assign last = fi == '1;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      bin_cnt <= '0;
      frame_idx <= '0;
      src_ready <= 1'b0;
      err_count <= '0;
      frame_done <= 1'b0;
      rd_data <= '0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      state <= state_n;
      bin_cnt <= bin_n;
      frame_idx <= fidx_n;
      src_ready <= 1'b1;
      err_count <= (abort && err_count != 8'hFF) ? err_count + 8'd1 : err_count;
      frame_done <= v2 && d2;
      rd_data <= res_ram[rd_addr];
      v1 <= proc;
      v2 <= v1;
      v3 <= v2;
    end
  end
  always_ff @(posedge clk) begin
    re1 <= src_real;
    im1 <= src_imag;
    a1 <= addr;
    f1 <= first;
    l1 <= last;
    d1 <= good && last;
    sq_re2 <= PW'(re1) * PW'(re1);
    sq_im2 <= PW'(im1) * PW'(im1);
    a2 <= a1;
    f2 <= f1;
    l2 <= l1;
    d2 <= d1;
    pwr3 <= sq_re2 + sq_im2;
    acc3 <= acc_q;
    a3 <= a2;
    f3 <= f2;
    l3 <= l2;
  end
  assign acc_new = f3 ? AW'(pwr3) : acc3 + AW'(pwr3);
  assign shifted = acc_new >> SH;
  assign res = (shifted > RMAX) ? '1 : shifted[OUT_W-1:0];
  always_ff @(posedge clk) begin
    acc_q <= acc_ram[a1];
    if (v3) acc_ram[a3] <= acc_new;
    if (v3 && l3) res_ram[a3] <= res;
  end
endmodule

// File: tb/tb_fft_pwr_avg.sv
// tb_fft_pwr_avg: directed scenarios for framing, averaging, saturation, aborts and reset
module tb_fft_pwr_avg;
  localparam int DW = 16, LN = 10, N = 1024, AL = 2, PS = 0, OW = 16;
  logic clk = 1'b0, reset_n = 1'b0, src_valid = 1'b0, src_sop = 1'b0, src_eop = 1'b0;
  logic src_ready, frame_done;
  logic [1:0] src_error = 2'b00;
  logic [DW-1:0] src_real = '0, src_imag = '0;
  logic [LN-1:0] rd_addr = '0;
  logic [OW-1:0] rd_data;
  logic [7:0] err_count;
  int nvec = 0, nerr = 0;
  int cyc = 0, eop_cyc = 0, done_cnt = 0, done_lat = 0;
  int base, bad, first_bad;

  always #5 clk = ~clk;

  fft_pwr_avg #(.DATA_W(DW), .LOG2_NPTS(LN), .NPTS(N), .AVG_LOG2(AL), .PWR_SHIFT(PS), .OUT_W(OW)) dut (
    .clk(clk), .reset_n(reset_n), .src_valid(src_valid), .src_ready(src_ready),
    .src_error(src_error), .src_sop(src_sop), .src_eop(src_eop),
    .src_real(src_real), .src_imag(src_imag), .rd_addr(rd_addr), .rd_data(rd_data),
    .frame_done(frame_done), .err_count(err_count)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (frame_done) begin
      done_cnt <= done_cnt + 1;
      done_lat <= cyc - eop_cyc;
    end
  end

  task automatic idle(input int n);
    @(negedge clk);
    src_valid = 1'b0; src_sop = 1'b0; src_eop = 1'b0; src_error = 2'b00;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; src_valid = 1'b0; src_sop = 1'b0; src_eop = 1'b0; src_error = 2'b00;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // bins 0..nbins-1; the final beat optionally carries eop or an error; alt uses a distinct pattern
  task automatic send_frame(input int gmax, input int nbins, input bit eop_end, input bit err_end, input bit alt);
    int g;
    for (int b = 0; b < nbins; b++) begin
      g = (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0;
      repeat (g) begin
        @(negedge clk);
        src_valid = 1'b0;
      end
      @(negedge clk);
      src_valid = 1'b1;
      src_sop = (b == 0);
      src_eop = eop_end && (b == nbins - 1);
      src_error = (err_end && b == nbins - 1) ? 2'b01 : 2'b00;
      src_real = alt ? 16'd100 : (b == 5 ? 16'h8000 : 16'd3);
      src_imag = alt ? 16'd0 : (b == 5 ? 16'h8000 : 16'd4);
      if (src_eop) eop_cyc = cyc;
    end
  endtask

  task automatic read_ram(output int nbad, output int fbad);
    nbad = 0; fbad = -1;
    for (int a = 0; a <= N; a++) begin
      @(negedge clk);
      if (a > 0 && rd_data !== ((a - 1) == 5 ? 16'hFFFF : 16'd25)) begin
        if (nbad == 0) fbad = a - 1;
        nbad++;
      end
      if (a < N) rd_addr = LN'(a);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    nvec++; if (src_ready !== 1'b0) begin nerr++; $display("FAIL reset_ready: got %b want 0", src_ready); end
    nvec++; if (rd_data !== 16'd0) begin nerr++; $display("FAIL reset_rd_data: got %0d want 0", rd_data); end
    nvec++; if (frame_done !== 1'b0) begin nerr++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    nvec++; if (err_count !== 8'd0) begin nerr++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
    reset_n = 1'b1;
    @(negedge clk);
    nvec++; if (src_ready !== 1'b1) begin nerr++; $display("FAIL release_ready: got %b want 1", src_ready); end
  endtask

  task automatic test_back_to_back(input int gmax, input string tag);
    do_reset();
    base = done_cnt;
    for (int f = 0; f < 4; f++) send_frame(gmax, N, 1'b1, 1'b0, 1'b0);
    idle(6);
    nvec++; if (done_cnt - base !== 1) begin nerr++; $display("FAIL %s_done_count: got %0d want 1", tag, done_cnt - base); end
    nvec++; if (done_lat !== 3) begin nerr++; $display("FAIL %s_done_latency: got %0d want 3", tag, done_lat); end
    nvec++; if (err_count !== 8'd0) begin nerr++; $display("FAIL %s_err_count: got %0d want 0", tag, err_count); end
    read_ram(bad, first_bad);
    nvec++; if (bad !== 0) begin nerr++; $display("FAIL %s_ram: got %0d bad bins (first %0d) want 0", tag, bad, first_bad); end
  endtask

  task automatic test_early_eop();
    do_reset();
    base = done_cnt;
    send_frame(0, 501, 1'b1, 1'b0, 1'b0);
    for (int f = 0; f < 3; f++) send_frame(0, N, 1'b1, 1'b0, 1'b0);
    idle(6);
    nvec++; if (done_cnt - base !== 0) begin nerr++; $display("FAIL eop_early_done: got %0d want 0", done_cnt - base); end
    send_frame(0, N, 1'b1, 1'b0, 1'b0);
    idle(6);
    nvec++; if (done_cnt - base !== 1) begin nerr++; $display("FAIL eop_done_count: got %0d want 1", done_cnt - base); end
    nvec++; if (err_count !== 8'd1) begin nerr++; $display("FAIL eop_err_count: got %0d want 1", err_count); end
    read_ram(bad, first_bad);
    nvec++; if (bad !== 0) begin nerr++; $display("FAIL eop_ram: got %0d bad bins (first %0d) want 0", bad, first_bad); end
  endtask

  task automatic test_sop_restart();
    do_reset();
    base = done_cnt;
    send_frame(0, N, 1'b1, 1'b0, 1'b0);
    send_frame(0, 300, 1'b0, 1'b0, 1'b1);
    for (int f = 0; f < 3; f++) send_frame(0, N, 1'b1, 1'b0, 1'b0);
    idle(6);
    nvec++; if (done_cnt - base !== 0) begin nerr++; $display("FAIL sop_early_done: got %0d want 0", done_cnt - base); end
    send_frame(0, N, 1'b1, 1'b0, 1'b0);
    idle(6);
    nvec++; if (done_cnt - base !== 1) begin nerr++; $display("FAIL sop_done_count: got %0d want 1", done_cnt - base); end
    nvec++; if (done_lat !== 3) begin nerr++; $display("FAIL sop_done_latency: got %0d want 3", done_lat); end
    nvec++; if (err_count !== 8'd1) begin nerr++; $display("FAIL sop_err_count: got %0d want 1", err_count); end
    read_ram(bad, first_bad);
    nvec++; if (bad !== 0) begin nerr++; $display("FAIL sop_ram: got %0d bad bins (first %0d) want 0", bad, first_bad); end
  endtask

  task automatic test_error_flag();
    do_reset();
    base = done_cnt;
    for (int f = 0; f < 2; f++) send_frame(0, N, 1'b1, 1'b0, 1'b0);
    send_frame(0, 11, 1'b0, 1'b1, 1'b0);
    idle(2);
    nvec++; if (err_count !== 8'd1) begin nerr++; $display("FAIL errflag_err_count: got %0d want 1", err_count); end
    for (int f = 0; f < 3; f++) send_frame(0, N, 1'b1, 1'b0, 1'b0);
    idle(6);
    nvec++; if (done_cnt - base !== 0) begin nerr++; $display("FAIL errflag_early_done: got %0d want 0", done_cnt - base); end
    send_frame(0, N, 1'b1, 1'b0, 1'b0);
    idle(6);
    nvec++; if (done_cnt - base !== 1) begin nerr++; $display("FAIL errflag_done_count: got %0d want 1", done_cnt - base); end
    read_ram(bad, first_bad);
    nvec++; if (bad !== 0) begin nerr++; $display("FAIL errflag_ram: got %0d bad bins (first %0d) want 0", bad, first_bad); end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    base = done_cnt;
    for (int f = 0; f < 2; f++) send_frame(0, N, 1'b1, 1'b0, 1'b0);
    send_frame(0, 200, 1'b0, 1'b0, 1'b1);
    do_reset();
    idle(4);
    nvec++; if (done_cnt - base !== 0) begin nerr++; $display("FAIL rstmid_done: got %0d want 0", done_cnt - base); end
    nvec++; if (err_count !== 8'd0) begin nerr++; $display("FAIL rstmid_err_count: got %0d want 0", err_count); end
    for (int f = 0; f < 3; f++) send_frame(0, N, 1'b1, 1'b0, 1'b0);
    idle(6);
    nvec++; if (done_cnt - base !== 0) begin nerr++; $display("FAIL rstmid_early_done: got %0d want 0", done_cnt - base); end
    send_frame(0, N, 1'b1, 1'b0, 1'b0);
    idle(6);
    nvec++; if (done_cnt - base !== 1) begin nerr++; $display("FAIL rstmid_done_count: got %0d want 1", done_cnt - base); end
    read_ram(bad, first_bad);
    nvec++; if (bad !== 0) begin nerr++; $display("FAIL rstmid_ram: got %0d bad bins (first %0d) want 0", bad, first_bad); end
  endtask

  initial begin
    test_reset();
    test_back_to_back(0, "b2b");
    test_back_to_back(5, "gaps");
    test_early_eop();
    test_sop_restart();
    test_error_flag();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/fft_pwr_avg.md
Name: fft_pwr_avg

Overview:
- Sits directly downstream of the streaming FFT and consumes its Avalon-ST source interface.
- Computes per-bin power (re^2 + im^2) and averages it over 2^AVG_LOG2 consecutive good frames.
- Publishes the scaled, saturated result in a result RAM. The display/readout logic reads that RAM through a random-access port.
- Malformed frames (bad sop/eop framing, error flags) are detected and cause a restart of the averaging group.

Parameters:
- DATA_W, 16: width of signed real/imag input samples.
- LOG2_NPTS, 10: log2 of frame length.
- NPTS, 1024: bins per frame; must equal 2^LOG2_NPTS and be >= 8.
- AVG_LOG2, 2: log2 of frames averaged per result.
- PWR_SHIFT, 16: extra right shift applied to the averaged power before saturation.
- OUT_W, 16: width of the result word.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- reset_n  in  1  synchronous, active-low reset.
- src_valid  in  1  FFT source_valid.
- src_ready  out  1  to FFT source_ready.
- src_error  in  2  FFT source_error; nonzero = bad beat.
- src_sop  in  1  first bin of a frame.
- src_eop  in  1  last bin of a frame.
- src_real  in  DATA_W  signed real part.
- src_imag  in  DATA_W  signed imaginary part.
- rd_addr  in  LOG2_NPTS  result RAM read address.
- rd_data  out  OUT_W  result word; registered, 1-cycle latency.
- frame_done  out  1  1-cycle pulse when a new averaged spectrum is complete.
- err_count  out  8  saturating count of aborted frames.

Behaviour:
- Reset (reset_n low at a clk edge):
  - src_ready=0, rd_data=0, frame_done=0, err_count=0.
  - state=IDLE, bin_cnt=0, frame_idx=0, all pipeline valids cleared.
  - Reset mid-frame drops in-flight writes. RAM contents are not cleared; results are undefined until the first frame_done.
- Handshake:
  - src_ready=1 whenever reset_n is high. The block never backpressures.
  - A beat is accepted when src_valid and src_ready are both 1. Gaps in src_valid are allowed anywhere.
- Pipeline (accepted beat at cycle T):
  - T+1: inputs registered; accumulator RAM read issued at bin_cnt.
  - T+2: re^2 and im^2 formed, each 2*DATA_W bits signed-to-unsigned.
  - T+3: pwr = re^2 + im^2, unsigned 2*DATA_W bits (max 2^31, no overflow).
  - T+3, accumulator: acc_new = pwr if frame_idx==0, else acc_old + pwr. Accumulator width is 2*DATA_W+AVG_LOG2. acc_new is written back.
  - T+3, last frame of the group (frame_idx == 2^AVG_LOG2-1): result = min(acc_new >> (AVG_LOG2+PWR_SHIFT), 2^OUT_W-1), written to result RAM at the same bin.
- Hazards: addresses within a frame are distinct and NPTS >= 8, so there is no read-modify-write hazard. No forwarding is required.
- FSM states:
  - IDLE: wait for an accepted beat with sop=1. Non-sop beats are ignored silently.
  - On a sop beat: bin 0 is processed, go to IN_FRAME with bin_cnt=1.
  - A sop beat with eop=1 also set is a malformed frame: abort (err_count+1, frame_idx=0) and stay in IDLE.
  - IN_FRAME: each accepted beat is processed at bin_cnt, then bin_cnt increments.
- Frame completion: an eop beat with bin_cnt==NPTS-1 (and no abort condition) is a good frame.
  - Return to IDLE and set frame_idx = (frame_idx+1) mod 2^AVG_LOG2.
  - If it was the last frame of the group, frame_done pulses exactly 3 cycles after the eop beat is accepted, i.e. the cycle its result write commits.
- Abort conditions, checked on every accepted beat in IN_FRAME:
  - (a) src_error != 0: abort, go to IDLE.
  - (b) eop with bin_cnt != NPTS-1: abort, go to IDLE.
  - (c) bin_cnt == NPTS-1 without eop: abort, go to IDLE.
  - (d) sop=1: abort the current frame, then start a new frame with this beat as bin 0 (state stays IN_FRAME, bin_cnt=1).
  - Every abort: err_count increments, saturating at 255, and frame_idx is reset to 0.
  - The aborting beat itself is not written, except in case (d), where it is written as bin 0 of the new frame.
- Accumulator corruption from an aborted frame is harmless: the next frame_idx==0 frame overwrites it.
- Simultaneous src_error!=0 and sop: treat as abort, go to IDLE; the beat is not processed.
- Read port:
  - rd_data = result_ram[rd_addr] registered on the next edge.
  - A read and a write to the same address in the same cycle returns the old data.

Test Plan:
1. Hold reset_n=0 for 3 cycles -> src_ready=0, rd_data=0, frame_done=0, err_count=0. Release -> src_ready=1 next cycle.
2. PWR_SHIFT=0, AVG_LOG2=2. Send 4 back-to-back good frames: all bins re=3, im=4; bin 5 re=im=-32768 -> exactly one frame_done, 3 cycles after the 4th eop. rd_data=25 at all bins except bin 5, where rd_data=65535 (saturated).
3. Repeat scenario 2 with random 0-5 cycle src_valid gaps -> identical RAM contents and one frame_done; err_count=0.
4. Send eop at bin 500, then 4 good frames -> err_count=1, no frame_done before the 4th good frame, results correct (25).
5. Assert sop at bin 300 of the 2nd frame, then continue that new frame plus 3 more good frames -> err_count=1; frame_done after the 4th frame counted from the restart; no corruption from the aborted frame.
6. Set src_error=2'b01 on bin 10 of frame 3 -> err_count=1, frame_idx=0. Separately, pulse reset_n low mid-frame -> no frame_done, err_count=0, next 4 good frames produce correct results.
